// File: rtl/decoder_if.sv
// Select/enable inputs and registered one-hot result of the binary-to-one-hot decoder.
// The master drives the select side; the decoder (slave) returns the decoded word.
interface decoder_if #(
  parameter int WIDTH = 16
);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic          enable;
  logic [SW-1:0] sel;
  logic [WIDTH-1:0] out;
  logic          sel_err;

  modport master (output enable, output sel, input out, input sel_err);
  modport slave  (input enable, input sel, output out, output sel_err);
endinterface

// File: rtl/decoder.sv
// Binary-to-one-hot decoder with enable and a registered output stage.
// Out-of-range selects (only possible for non-power-of-two WIDTH) give zero plus sel_err.
module decoder #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  decoder_if.slave  bus
);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] out_q;
  logic             err_q;
  logic             in_range;

  assign one = {{(WIDTH-1){1'b0}}, 1'b1};

  // A power-of-two WIDTH cannot be exceeded by an SW-bit index.
  generate
    if ((2 ** SW) == WIDTH) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = (bus.sel <= SW'(WIDTH - 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else if (bus.enable) begin
      if (in_range) begin
        out_q <= one << bus.sel;
        err_q <= 1'b0;
      end else begin
        out_q <= '0;
        err_q <= 1'b1;
      end
    end else begin
      out_q <= '0;
      err_q <= 1'b0;
    end
  end

  assign bus.out     = out_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: a 16-wide and a 10-wide instance driven in lockstep,
// checked against an arithmetic model of the decode rules.
module tb_decoder;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  decoder_if #(.WIDTH(16)) if16 ();
  decoder_if #(.WIDTH(10)) if10 ();

  decoder #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  decoder #(.WIDTH(10)) dut10 (.clk(clk), .reset(reset), .bus(if10.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_out(int w, bit rst, bit en, int s);
    if (!rst) return 32'd0;
    if (en && s < w) return 32'd1 << s;
    return 32'd0;
  endfunction

  function automatic logic model_err(int w, bit rst, bit en, int s);
    return rst && en && (s >= w);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Apply inputs, take one edge, then compare both instances against the model.
  task automatic step(input string tag, input bit rst, input bit en, input int s);
    logic [31:0] e16, e10;
    logic        x16, x10;
    reset       = rst;
    if16.enable = en;
    if16.sel    = 4'(s);
    if10.enable = en;
    if10.sel    = 4'(s);
    e16 = model_out(16, rst, en, s);
    e10 = model_out(10, rst, en, s);
    x16 = model_err(16, rst, en, s);
    x10 = model_err(10, rst, en, s);
    @(posedge clk);
    #1;
    check({tag, ":out16"}, 32'(if16.out), e16);
    check({tag, ":err16"}, 32'(if16.sel_err), 32'(x16));
    check({tag, ":out10"}, 32'(if10.out), e10);
    check({tag, ":err10"}, 32'(if10.sel_err), 32'(x10));
    check({tag, ":onehot16"}, 32'($countones(if16.out) <= 1), 32'd1);
    check({tag, ":onehot10"}, 32'($countones(if10.out) <= 1), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    if16.enable = 1'b0;
    if16.sel    = '0;
    if10.enable = 1'b0;
    if10.sel    = '0;

    for (int i = 0; i < 4; i++) step("reset_hold", 1'b0, 1'b1, 5);

    for (int s = 0; s < 16; s++) begin
      step("sweep_en", 1'b1, 1'b1, s);
      step("sweep_en_hold", 1'b1, 1'b1, s);
    end

    for (int s = 0; s < 16; s++) step("sweep_dis", 1'b1, 1'b0, s);

    step("toggle_a", 1'b1, 1'b1, 3);
    step("toggle_b", 1'b1, 1'b0, 3);
    step("toggle_c", 1'b1, 1'b1, 3);

    step("mid_pre", 1'b1, 1'b1, 7);
    step("mid_rst", 1'b0, 1'b1, 7);
    step("mid_post", 1'b1, 1'b1, 7);

    step("oor_9", 1'b1, 1'b1, 9);
    step("oor_12", 1'b1, 1'b1, 12);
    step("oor_12_dis", 1'b1, 1'b0, 12);
    step("oor_15", 1'b1, 1'b1, 15);
    step("oor_10", 1'b1, 1'b1, 10);

    for (int i = 0; i < 300; i++) begin
      bit r;
      r = ($urandom_range(0, 15) != 0);
      step("random", r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
